instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Inverse of the immediate generator: packs register fields, funct bits and a full 32-bit signed immediate into a legal RV32I instruction word.
- Streams encoded words with sequential addresses to an instruction-memory write port, with valid/ready on both sides.
- Used by the boot/program-load path and the self-check bench to build IMEM images in hardware.

Parameters:
- ADDR_W, 32, width of write address / address counter.
- MAX_WORDS, 1024, number of words emitted per session before the block stops accepting.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- i_start  in  1  one-cycle pulse: load i_base_addr, clear count, enter RUN
- i_base_addr  in  ADDR_W  start address, must be word aligned
- i_req_valid  in  1  request valid
- o_req_ready  out  1  request accepted when valid&ready
- i_fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J 6=SHIFT (I-type shamt), 7=reserved
- i_opcode  in  7  opcode[6:0]
- i_rd, i_rs1, i_rs2  in  5 each  register indices
- i_funct3  in  3; i_funct7  in  7
- i_imm  in  32  signed immediate, byte offset for B/J, full value for U
- o_instr_valid  out  1  output word valid
- i_instr_ready  in  1  memory accepts word
- o_instr  out  32  encoded word
- o_addr  out  ADDR_W  write address of o_instr
- o_count  out  ADDR_W  words emitted this session
- o_busy  out  1  state==RUN
- o_instr_err  out  1  range error for the current o_instr (feature only)

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset: state IDLE; o_req_ready=0; o_instr_valid=0; o_instr=0; o_addr=0; o_count=0; o_busy=0; o_instr_err=0.
- States:
  - IDLE: ready=0. i_start -> RUN.
  - RUN: ready = !o_instr_valid | i_instr_ready.
  - FULL: ready=0. i_start -> RUN.
- Accept: registers the encoded word; o_instr_valid=1 the next cycle (latency 1).
- Output hold: o_instr, o_addr and o_instr_err are held stable while valid & !i_instr_ready.
- Output handshake (valid&ready):
  - o_addr += 4, wrapping modulo 2^ADDR_W; o_count += 1.
  - Simultaneous accept reloads the output register in the same cycle, so a continuous stream runs at 1 word/cycle.
- FULL entry: when o_count reaches MAX_WORDS on a handshake. Nothing further is accepted until i_start; the final word completes normally.
- i_start during RUN: discards any pending output (valid->0), reloads o_addr=i_base_addr, o_count=0. A request in the same cycle is not accepted.
- Reset mid-transfer: pending word is dropped; all outputs return to reset values.
- Encoding, with instr[6:0]=i_opcode:
  - R: f7|rs2|rs1|f3|rd
  - I: imm[11:0]|rs1|f3|rd
  - SHIFT: f7|imm[4:0]|rs1|f3|rd
  - S: imm[11:5]|rs2|rs1|f3|imm[4:0]|opcode
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]
  - U: imm[31:12]|rd
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd
  - fmt 7: emits 0x00000013 (nop).
- Out-of-range bits are silently truncated unless the feature below is enabled.

Optional Feature:
- Macro: IMMENC_RANGE_CHECK_EN.
- Defined: each accepted request is range-checked; o_instr_err=1 travels with the word, which is still emitted truncated. Violations:
  - I/S: imm outside [-2048,2047]
  - B: imm outside [-4096,4094] or imm[0]=1
  - J: imm outside [-1048576,1048574] or imm[0]=1
  - U: imm[11:0]!=0
  - SHIFT: imm[31:5]!=0
  - fmt 7: always an error
- Undefined: no check logic; o_instr_err tied 0.

Test Plan:
- i_start base 0x100; I addi rd=1 rs1=0 f3=0 op=0x13 imm=0xFFFFFFFF -> o_instr=0xFFF00093, o_addr=0x100, valid one cycle after accept.
- B op=0x63 f3=0 rs1=1 rs2=2 imm=-8 -> 0xFE208CE3; then J op=0x6F rd=1 imm=0x800 -> 0x001000EF at o_addr 0x104.
- U op=0x37 rd=5 imm=0x12345000 -> 0x123452B7; stream 8 back-to-back requests with ready=1 -> 8 words in 8 consecutive cycles, addresses +4 each.
- i_instr_ready low 3 cycles -> o_instr/o_addr stable, o_req_ready=0, o_count unchanged until handshake.
- MAX_WORDS=4: 4 handshakes -> FULL, o_req_ready=0, o_busy=0; i_start base 0x0 -> RUN, o_count=0, next word at 0x0. Base 0xFFFFFFFC -> second word at 0x0 (wrap).
- With IMMENC_RANGE_CHECK_EN: I imm=2048 -> o_instr_err=1, imm field 0x800; B imm=6 -> err=0; B imm=5 -> err=1; i_start mid-stall -> pending word dropped.

Source files
------------

// File: rtl/instr_encoder.sv
// ----------------------------------------------------------------------------
// instr_encoder
//   Packs register fields, funct bits and a 32-bit signed immediate into an
//   RV32I instruction word and streams the words, with sequential word
//   addresses, to an instruction-memory write port (valid/ready both sides).
//
//   Optional build macro: IMMENC_RANGE_CHECK_EN
//     defined   -> each accepted request is range-checked; o_instr_err travels
//                  with the (still truncated) word.
//     undefined -> no check logic, o_instr_err is constant 0.
//
// Ports
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_start, i_base_addr  start a session at a word-aligned base address
//   i_req_valid/o_req_ready  request handshake
//   i_fmt, i_opcode, i_rd, i_rs1, i_rs2, i_funct3, i_funct7, i_imm  fields
//   o_instr_valid/i_instr_ready  output word handshake
//   o_instr, o_addr       encoded word and its write address
//   o_count               words emitted this session
//   o_busy                session running
//   o_instr_err           range error flag for the current o_instr
// ----------------------------------------------------------------------------
module instr_encoder #(
    parameter int ADDR_W    = 32,
    parameter int MAX_WORDS = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [2:0]        i_fmt,
    input  logic [6:0]        i_opcode,
    input  logic [4:0]        i_rd,
    input  logic [4:0]        i_rs1,
    input  logic [4:0]        i_rs2,
    input  logic [2:0]        i_funct3,
    input  logic [6:0]        i_funct7,
    input  logic [31:0]       i_imm,
    output logic              o_instr_valid,
    input  logic              i_instr_ready,
    output logic [31:0]       o_instr,
    output logic [ADDR_W-1:0] o_addr,
    output logic [ADDR_W-1:0] o_count,
    output logic              o_busy,
    output logic              o_instr_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    localparam logic [2:0] FMT_R     = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHIFT = 3'd6;

    localparam logic [31:0]       LP_NOP    = 32'h0000_0013;
    localparam logic [ADDR_W:0]   LP_MAX    = (ADDR_W+1)'(MAX_WORDS);
    localparam logic [ADDR_W:0]   LP_ONE_W  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] LP_STEP   = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] LP_ONE    = ADDR_W'(1);

`ifdef IMMENC_RANGE_CHECK_EN
    // True when bits [31:lsb] are a pure sign extension of bit lsb.
    function automatic logic f_sext_ok(input logic [31:0] imm, input int lsb);
        logic [31:0] top_mask;
        top_mask = 32'hFFFF_FFFF << lsb;
        return ((imm & top_mask) == 32'h0000_0000) || ((imm & top_mask) == top_mask);
    endfunction

    // Range violation for one request; fmt 7 (nop) is always flagged.
    function automatic logic f_range_err(input logic [2:0] fmt, input logic [31:0] imm);
        logic err;
        case (fmt)
            FMT_I, FMT_S: err = !f_sext_ok(imm, 11);
            FMT_B:        err = !f_sext_ok(imm, 12) || imm[0];
            FMT_J:        err = !f_sext_ok(imm, 20) || imm[0];
            FMT_U:        err = (imm[11:0] != 12'h000);
            FMT_SHIFT:    err = (imm[31:5] != 27'd0);
            FMT_R:        err = 1'b0;
            default:      err = 1'b1;
        endcase
        return err;
    endfunction
`endif

    state_t            r_state;
    state_t            w_state_next;
    logic              r_instr_valid;
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_count;
    logic              r_err;

    logic [31:0]       w_enc;
    logic              w_err;
    logic              w_req_ready;
    logic              w_accept;
    logic              w_out_hs;
    logic              w_room;
    logic              w_last_hs;

    // Words accepted so far (emitted + pending) must stay below the session limit.
    assign w_room    = ({1'b0, r_count} + {{ADDR_W{1'b0}}, r_instr_valid}) < LP_MAX;
    assign w_out_hs  = r_instr_valid && i_instr_ready;
    assign w_last_hs = w_out_hs && (({1'b0, r_count} + LP_ONE_W) == LP_MAX);
    assign w_accept  = i_req_valid && w_req_ready;

    // Field packing for each instruction format.
    always_comb begin
        w_enc = LP_NOP;
        case (i_fmt)
            FMT_R:     w_enc = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
            FMT_I:     w_enc = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
            FMT_SHIFT: w_enc = {i_funct7, i_imm[4:0], i_rs1, i_funct3, i_rd, i_opcode};
            FMT_S:     w_enc = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
            FMT_B:     w_enc = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                                i_imm[4:1], i_imm[11], i_opcode};
            FMT_U:     w_enc = {i_imm[31:12], i_rd, i_opcode};
            FMT_J:     w_enc = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12],
                                i_rd, i_opcode};
            default:   w_enc = LP_NOP;
        endcase
    end

    // Range flag that travels with the accepted word.
    always_comb begin
`ifdef IMMENC_RANGE_CHECK_EN
        w_err = f_range_err(i_fmt, i_imm);
`else
        w_err = 1'b0;
`endif
    end

    // Request ready: only while running, never in a start cycle, and only when
    // the output slot frees up this cycle and the session has room left.
    always_comb begin
        w_req_ready = 1'b0;
        if ((r_state == ST_RUN) && !i_start && w_room) begin
            w_req_ready = !r_instr_valid || i_instr_ready;
        end else begin
            w_req_ready = 1'b0;
        end
    end

    // Next-state logic; i_start always (re)enters RUN.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) w_state_next = ST_RUN;
                else         w_state_next = ST_IDLE;
            end
            ST_RUN: begin
                if (i_start)        w_state_next = ST_RUN;
                else if (w_last_hs) w_state_next = ST_FULL;
                else                w_state_next = ST_RUN;
            end
            ST_FULL: begin
                if (i_start) w_state_next = ST_RUN;
                else         w_state_next = ST_FULL;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State, output word register, address and count.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_instr_valid <= 1'b0;
            r_instr       <= 32'h0000_0000;
            r_addr        <= {ADDR_W{1'b0}};
            r_count       <= {ADDR_W{1'b0}};
            r_err         <= 1'b0;
        end else if (i_start) begin
            // A new session drops any pending word.
            r_state       <= w_state_next;
            r_instr_valid <= 1'b0;
            r_addr        <= i_base_addr;
            r_count       <= {ADDR_W{1'b0}};
            r_err         <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_out_hs) begin
                r_addr  <= r_addr + LP_STEP;
                r_count <= r_count + LP_ONE;
            end
            if (w_accept) begin
                r_instr       <= w_enc;
                r_err         <= w_err;
                r_instr_valid <= 1'b1;
            end else if (w_out_hs) begin
                r_instr_valid <= 1'b0;
            end
        end
    end

    assign o_req_ready   = w_req_ready;
    assign o_instr_valid = r_instr_valid;
    assign o_instr       = r_instr;
    assign o_addr        = r_addr;
    assign o_count       = r_count;
    assign o_busy        = (r_state == ST_RUN);
    assign o_instr_err   = r_err;

endmodule
